imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_extract.sv | 123 ++++++++++++
 rtl/imm_decode_stage.sv | 102 ++++++++++
 tb/tb_imm_decode_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-format encoding and width check
// for the immediate decode stage.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_type_t;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor: instruction word to
// immediate value, format and illegal flag.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] u_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] sh_imm;
  logic [XLEN-1:0] shw_imm;

  assign i_imm = XLEN'($signed(instr[31:20]));
  assign s_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign b_imm = XLEN'($signed({instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0}));
  assign u_imm = XLEN'($signed({instr[31:12], 12'b0}));
  assign j_imm = XLEN'($signed({instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0}));

  // shift amounts are unsigned; RV64 borrows instr[25] for bit 5
  assign sh_imm  = IS64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
  assign shw_imm = XLEN'(instr[24:20]);

  logic sh_op;
  logic hi_zero;
  logic hi_sra;
  logic w_zero;
  logic w_sra;
  logic sh_ok;
  logic shw_ok;

  assign sh_op   = (f3[1:0] == 2'b01);
  assign hi_zero = IS64 ? (f7[6:1] == 6'd0) : (f7 == 7'd0);
  assign hi_sra  = IS64 ? (f7[6:1] == 6'b010000) : (f7 == 7'b0100000);
  assign w_zero  = (f7 == 7'd0);
  assign w_sra   = (f7 == 7'b0100000);
  assign sh_ok   = hi_zero | (f3[2] & hi_sra);
  assign shw_ok  = w_zero | (f3[2] & w_sra);

  logic is_i;
  logic is_s;
  logic is_b;
  logic is_u;
  logic is_j;
  logic is_sh;
  logic is_shw;
  logic is_none;

  assign is_i = (opc == OPC_LOAD) | (opc == OPC_JALR)
              | (opc == OPC_MISC_MEM) | (opc == OPC_SYSTEM)
              | ((opc == OPC_OP_IMM) & ~sh_op)
              | (IS64 & (opc == OPC_OP_IMM_32) & (f3 == 3'b000));
  assign is_s    = (opc == OPC_STORE);
  assign is_b    = (opc == OPC_BRANCH);
  assign is_u    = (opc == OPC_LUI) | (opc == OPC_AUIPC);
  assign is_j    = (opc == OPC_JAL);
  assign is_sh   = (opc == OPC_OP_IMM) & sh_op & sh_ok;
  assign is_shw  = IS64 & (opc == OPC_OP_IMM_32) & sh_op & shw_ok;
  assign is_none = (opc == OPC_OP) | (IS64 & (opc == OPC_OP_32));

  imm_type_t t;

  always_comb begin
    imm     = '0;
    t       = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm = i_imm;
        t   = IMM_I;
      end
      is_s: begin
        imm = s_imm;
        t   = IMM_S;
      end
      is_b: begin
        imm = b_imm;
        t   = IMM_B;
      end
      is_u: begin
        imm = u_imm;
        t   = IMM_U;
      end
      is_j: begin
        imm = j_imm;
        t   = IMM_J;
      end
      is_sh: begin
        imm = sh_imm;
        t   = IMM_SHAMT;
      end
      is_shw: begin
        imm = shw_imm;
        t   = IMM_SHAMT;
      end
      is_none: t = IMM_NONE;
      default: illegal = 1'b1;
    endcase
  end

  assign imm_type = t;

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extractor followed by a two-entry
// output/skid buffer with a registered ready.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_imm_type,
  output logic             o_illegal,
  output logic [31:0]      o_instr,
  output logic [TAG_W-1:0] o_tag
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       ty;
    logic             ill;
  } entry_t;

  logic [XLEN-1:0] x_imm;
  logic [2:0]      x_ty;
  logic            x_ill;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr   (i_instr),
    .imm     (x_imm),
    .imm_type(x_ty),
    .illegal (x_ill)
  );

  entry_t in_e;
  entry_t out_q;
  entry_t skid_q;
  logic   out_v;
  logic   skid_v;

  assign in_e.instr = i_instr;
  assign in_e.tag   = i_tag;
  assign in_e.imm   = x_imm;
  assign in_e.ty    = x_ty;
  assign in_e.ill   = x_ill;

  logic acc;

  // ready comes straight from the skid flop, so it is registered
  assign o_ready = ~skid_v;
  assign acc     = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (i_flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (i_ready) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (acc) begin
      if (!out_v || i_ready) begin
        out_q <= in_e;
        out_v <= 1'b1;
      end else begin
        skid_q <= in_e;
        skid_v <= 1'b1;
      end
    end else if (out_v && i_ready) begin
      out_v <= 1'b0;
    end
  end

  assign o_valid    = out_v;
  assign o_imm      = out_q.imm;
  assign o_imm_type = out_q.ty;
  assign o_illegal  = out_q.ill;
  assign o_instr    = out_q.instr;
  assign o_tag      = out_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: random and directed traffic
// checked against an arithmetic reference model.
module tb_imm_decode_stage;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             o_ready;
  logic [31:0]      in_instr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             o_valid;
  logic             in_ready = 1'b0;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_imm_type;
  logic             o_illegal;
  logic [31:0]      o_instr;
  logic [TAG_W-1:0] o_tag;

  imm_decode_stage #(
    .XLEN (XLEN),
    .TAG_W(TAG_W)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (flush),
    .i_valid   (in_valid),
    .o_ready   (o_ready),
    .i_instr   (in_instr),
    .i_tag     (in_tag),
    .o_valid   (o_valid),
    .i_ready   (in_ready),
    .o_imm     (o_imm),
    .o_imm_type(o_imm_type),
    .o_illegal (o_illegal),
    .o_instr   (o_instr),
    .o_tag     (o_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       ty;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (longint'(1) << bits) : v;
  endfunction

  function automatic exp_t model(input logic [31:0] x,
                                 input logic [TAG_W-1:0] t);
    exp_t   e;
    longint v = 0;
    int     ty = 0;
    bit     ok = 1;
    int     op = int'(x[6:0]);
    int     f3 = int'(x[14:12]);
    int     hi = int'(x[31:25]);
    int     lim;
    case (op)
      3, 15, 103, 115: begin
        v = sext(longint'(x[31:20]), 12); ty = 1;
      end
      19: begin
        if (f3 == 1 || f3 == 5) begin
          lim = (XLEN == 64) ? hi / 2 : hi;
          ok = (lim == 0) || (f3 == 5 && lim == ((XLEN == 64) ? 16 : 32));
          v = (XLEN == 64) ? longint'(x[25:20]) : longint'(x[24:20]);
          ty = 6;
        end else begin
          v = sext(longint'(x[31:20]), 12); ty = 1;
        end
      end
      35: begin
        v = sext(longint'(x[31:25]) * 32 + longint'(x[11:7]), 12); ty = 2;
      end
      99: begin
        v = longint'(x[31]) * 4096 + longint'(x[7]) * 2048
          + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2;
        v = sext(v, 13); ty = 3;
      end
      23, 55: begin
        v = sext(longint'(x[31:12]) * 4096, 32); ty = 4;
      end
      111: begin
        v = longint'(x[31]) * 1048576 + longint'(x[19:12]) * 4096
          + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2;
        v = sext(v, 21); ty = 5;
      end
      51: ty = 0;
      27: begin
        if (XLEN != 64) ok = 0;
        else if (f3 == 0) begin
          v = sext(longint'(x[31:20]), 12); ty = 1;
        end else if (f3 == 1 || f3 == 5) begin
          ok = (hi == 0) || (f3 == 5 && hi == 32);
          v = longint'(x[24:20]); ty = 6;
        end else ok = 0;
      end
      59: ok = (XLEN == 64);
      default: ok = 0;
    endcase
    if (!ok) begin
      v = 0; ty = 0;
    end
    e.instr = x;
    e.tag   = t;
    e.imm   = v[XLEN-1:0];
    e.ty    = ty[2:0];
    e.ill   = !ok;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[14] = '{7'd3, 7'd15, 7'd19, 7'd19, 7'd23, 7'd27, 7'd35,
                            7'd51, 7'd55, 7'd59, 7'd99, 7'd103, 7'd111,
                            7'd115};
    logic [31:0] x = $urandom;
    int k = $urandom_range(0, 14);
    if (k < 14) x[6:0] = ops[k];
    if ($urandom_range(0, 1) == 1)
      x[31:26] = ($urandom_range(0, 1) == 1) ? 6'b000000 : 6'b010000;
    if ($urandom_range(0, 1) == 1) x[25] = 1'b0;
    return x;
  endfunction

  // one clock: drive at the falling edge, log the accept just after
  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic [TAG_W-1:0] t, input logic rdy,
                       input logic fl, input logic rs);
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    in_tag   = t;
    in_ready = rdy;
    flush    = fl;
    rst_n    = rs;
    #1;
    if (!rs || fl) sb.delete();
    else if (v && o_ready) sb.push_back(model(ins, t));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && !flush && o_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: instr %h with empty scoreboard",
                   o_instr);
        end else begin
          e = sb[0];
          check("out_instr", o_instr, e.instr);
          check("out_tag", o_tag, e.tag);
          check("out_imm", o_imm, e.imm);
          check("out_type", o_imm_type, e.ty);
          check("out_illegal", o_illegal, e.ill);
          if (in_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 1);
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_imm", o_imm, 0);
    check("rst_type", o_imm_type, 0);
    check("rst_illegal", o_illegal, 0);

    cycle(1, 32'hFFF00093, 32'h100, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("addi_valid", o_valid, 1);
    check("addi_imm", o_imm, 32'hFFFFFFFF);
    check("addi_type", o_imm_type, 1);
    check("addi_illegal", o_illegal, 0);

    cycle(1, 32'h4030D093, 32'h104, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("srai_imm", o_imm, 3);
    check("srai_type", o_imm_type, 6);

    cycle(1, 32'h02109093, 32'h108, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("slli33_illegal", o_illegal, (XLEN == 32) ? 1 : 0);
    check("slli33_imm", o_imm, (XLEN == 32) ? 0 : 33);

    cycle(1, 32'h00000000, 32'h10C, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("zero_illegal", o_illegal, 1);
    check("zero_type", o_imm_type, 0);
    check("zero_imm", o_imm, 0);

    cycle(1, 32'hFE000EE3, 32'h200, 0, 0, 1);
    cycle(1, 32'h123452B7, 32'h204, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    check("skid_ready_low", o_ready, 0);
    check("skid_head_imm", o_imm, 32'hFFFFFFFC);
    check("skid_head_type", o_imm_type, 3);
    cycle(0, '0, '0, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("skid_second_imm", o_imm, 32'h12345000);
    check("skid_second_type", o_imm_type, 4);
    check("skid_ready_back", o_ready, 1);
    cycle(0, '0, '0, 0, 0, 1);
    check("skid_drained", o_valid, 0);

    cycle(1, 32'h00500093, 32'h300, 0, 0, 1);
    cycle(1, 32'h00A00113, 32'h304, 0, 0, 1);
    cycle(0, '0, '0, 1, 1, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("flush_valid", o_valid, 0);
    check("flush_ready", o_ready, 1);

    cycle(1, 32'h00500093, 32'h400, 0, 0, 1);
    cycle(1, 32'h00A00113, 32'h404, 0, 0, 1);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 1);
    check("mrst_valid", o_valid, 0);
    check("mrst_ready", o_ready, 1);
    check("mrst_instr", o_instr, 0);
    check("mrst_tag", o_tag, 0);

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 60, rand_instr(), $urandom,
            $urandom_range(0, 99) < 70, $urandom_range(0, 49) == 0,
            $urandom_range(0, 399) != 0);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++)
      cycle(0, '0, '0, 1, 0, 1);
    cycle(0, '0, '0, 1, 0, 1);
    check("final_drain", sb.size(), 0);
    check("final_idle", o_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
